// File: rtl/softmax_pkg.sv
// softmax_pkg: shared state encoding, default sizes and width helpers for the softmax sequencer
package softmax_pkg;
   typedef enum logic [2:0] {
      st_idle,
      st_clear,
      st_load,
      st_sum,
      st_rd,
      st_div,
      st_done
   } state_e;
   localparam int unsigned def_data_size      = 32;
   localparam int unsigned def_number_of_data = 10;
   localparam int unsigned def_timeout_cycles = 64;
   // width of an index that addresses 0..n-1
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
   // width of a counter that must hold the value n itself
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/softmax_idx_counter.sv
// softmax_idx_counter: saturating up-counter with synchronous clear, enable and at_max flag
module softmax_idx_counter #(
   parameter int unsigned max_val = 10,
   parameter int unsigned width   = 4
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [width-1:0] cnt_o,
   output logic             at_max_o
);
   localparam logic [width-1:0] max_c = width'(max_val);
   logic [width-1:0] cnt_q, cnt_d;
   // clear wins over enable; counting stops at max_val
   always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != max_c) ? cnt_q + 1'b1 : cnt_q;
   // count register
   always_ff @(posedge clock_i or posedge reset_i)
      if (reset_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign cnt_o    = cnt_q;
   assign at_max_o = cnt_q == max_c;
endmodule

// File: rtl/softmax_ctrl.sv
// softmax_ctrl: sequencer for one softmax vector pass (load -> sum -> per-element divide).
// Optional divider/adder watchdog enabled by defining SOFTMAX_CTRL_TIMEOUT_EN.
module softmax_ctrl
   import softmax_pkg::*;
#(
   parameter int unsigned data_size      = def_data_size,
   parameter int unsigned number_of_data = def_number_of_data,
   parameter int unsigned timeout_cycles = def_timeout_cycles
) (
   input  logic                              clock_i,
   input  logic                              reset_i,
   input  logic                              start_i,
   input  logic                              data_valid_i,
   output logic                              data_ready_o,
   input  logic                              exp_valid_i,
   output logic                              adder_rst_n_o,
   output logic                              exp_done_o,
   input  logic                              sum_valid_i,
   output logic                              buf_rd_en_o,
   output logic [idx_w(number_of_data)-1:0]  buf_rd_addr_o,
   output logic                              div_start_o,
   input  logic                              div_done_i,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              error_o
);
   localparam int unsigned cw = cnt_w(number_of_data);
   localparam int unsigned iw = idx_w(number_of_data);
   localparam logic [cw-1:0] last_c = cw'(number_of_data - 1);

   if (number_of_data < 2 || data_size == 0 || timeout_cycles == 0) begin : g_bad_cfg
      $error("softmax_ctrl: invalid parameter set");
   end

   state_e state_q, state_d;
   logic data_ready_q, data_ready_d, adder_rst_n_q, adder_rst_n_d, exp_done_q, exp_done_d;
   logic buf_rd_en_q, buf_rd_en_d, div_start_q, div_start_d, busy_q, busy_d, done_q, done_d;
   logic cnt_clr, in_en, exp_en, in_max, exp_max, in_full, exp_full, idx_clr, idx_en, idx_max, tmo;
   logic [cw-1:0] in_cnt, exp_cnt;

   assign cnt_clr  = state_q == st_clear;
   assign in_en    = state_q == st_load && data_valid_i && data_ready_q;
   assign exp_en   = state_q == st_load && exp_valid_i;
   // "full" looks one cycle ahead so ready/exp_done switch right after the last event
   assign in_full  = state_q == st_load && (in_max || (in_en && in_cnt == last_c));
   assign exp_full = exp_max || (exp_en && exp_cnt == last_c);
   assign idx_clr  = state_q == st_sum && sum_valid_i;
   assign idx_en   = state_q == st_div && div_done_i;

   softmax_idx_counter #(.max_val(number_of_data), .width(cw)) u_in_cnt (
      .clock_i(clock_i), .reset_i(reset_i), .clr_i(cnt_clr), .en_i(in_en),
      .cnt_o(in_cnt), .at_max_o(in_max)
   );
   softmax_idx_counter #(.max_val(number_of_data), .width(cw)) u_exp_cnt (
      .clock_i(clock_i), .reset_i(reset_i), .clr_i(cnt_clr), .en_i(exp_en),
      .cnt_o(exp_cnt), .at_max_o(exp_max)
   );
   softmax_idx_counter #(.max_val(number_of_data - 1), .width(iw)) u_idx_cnt (
      .clock_i(clock_i), .reset_i(reset_i), .clr_i(idx_clr), .en_i(idx_en),
      .cnt_o(buf_rd_addr_o), .at_max_o(idx_max)
   );

`ifdef SOFTMAX_CTRL_TIMEOUT_EN
   localparam int unsigned tw = $clog2(timeout_cycles + 1);
   logic [tw-1:0] tmo_q, tmo_d;
   logic error_q, error_d;
   assign tmo = (state_q == st_sum || state_q == st_div) && tmo_q == tw'(timeout_cycles - 1);
   // watchdog restarts on every state entry; error is cleared only by the next CLEAR
   always_comb begin
      tmo_d   = (state_d != state_q) ? '0 : (state_q == st_sum || state_q == st_div) ? tmo_q + 1'b1 : tmo_q;
      error_d = (state_d == st_clear) ? 1'b0 : (tmo | error_q);
   end
   // watchdog and sticky error registers
   always_ff @(posedge clock_i or posedge reset_i)
      if (reset_i) begin
         tmo_q   <= '0;
         error_q <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         error_q <= error_d;
      end
   assign error_o = error_q;
`else
   assign tmo     = 1'b0;
   assign error_o = 1'b0;
`endif

   // next-state logic; the watchdog overrides any wait
   always_comb begin
      state_d = state_q;
      case (state_q)
         st_idle:  state_d = start_i ? st_clear : st_idle;
         st_clear: state_d = st_load;
         st_load:  state_d = exp_full ? st_sum : st_load;
         st_sum:   state_d = tmo ? st_done : sum_valid_i ? st_rd : st_sum;
         st_rd:    state_d = st_div;
         st_div:   state_d = tmo ? st_done : !div_done_i ? st_div : idx_max ? st_done : st_rd;
         st_done:  state_d = st_idle;
         default:  state_d = st_idle;
      endcase
   end

   // outputs decoded from the next state so every strobe leaves a flop
   always_comb begin
      data_ready_d  = state_d == st_load && !in_full;
      adder_rst_n_d = state_d != st_clear;
      exp_done_d    = state_d == st_sum;
      buf_rd_en_d   = state_d == st_rd;
      div_start_d   = state_d == st_div && state_q != st_div;
      busy_d        = state_d != st_idle;
      done_d        = state_d == st_done;
   end

   // state and registered outputs
   always_ff @(posedge clock_i or posedge reset_i)
      if (reset_i) begin
         state_q       <= st_idle;
         data_ready_q  <= 1'b0;
         adder_rst_n_q <= 1'b1;
         exp_done_q    <= 1'b0;
         buf_rd_en_q   <= 1'b0;
         div_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         data_ready_q  <= data_ready_d;
         adder_rst_n_q <= adder_rst_n_d;
         exp_done_q    <= exp_done_d;
         buf_rd_en_q   <= buf_rd_en_d;
         div_start_q   <= div_start_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end

   assign data_ready_o  = data_ready_q;
   assign adder_rst_n_o = adder_rst_n_q;
   assign exp_done_o    = exp_done_q;
   assign buf_rd_en_o   = buf_rd_en_q;
   assign div_start_o   = div_start_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
endmodule

// File: tb/tb_softmax_ctrl.sv
// tb_softmax_ctrl: directed bench for softmax_ctrl with small exp/adder/divider stand-ins
module tb_softmax_ctrl;
   localparam int n = 10;
   logic clock_i = 1'b0, reset_i = 1'b1, start_i = 1'b0, data_valid_i = 1'b0;
   logic exp_valid_i = 1'b0, sum_valid_i = 1'b0, div_done_i = 1'b0;
   logic data_ready_o, adder_rst_n_o, exp_done_o, buf_rd_en_o, div_start_o, busy_o, done_o, error_o;
   logic [3:0] buf_rd_addr_o;

   softmax_ctrl #(.data_size(32), .number_of_data(n), .timeout_cycles(64)) dut (
      .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
      .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .exp_valid_i(exp_valid_i),
      .adder_rst_n_o(adder_rst_n_o), .exp_done_o(exp_done_o), .sum_valid_i(sum_valid_i),
      .buf_rd_en_o(buf_rd_en_o), .buf_rd_addr_o(buf_rd_addr_o), .div_start_o(div_start_o),
      .div_done_i(div_done_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
   );

   always #5 clock_i = ~clock_i;

   int n_chk = 0, n_bad = 0, cyc = 0;
   int n_hs, n_exp, n_rd, rd_bad, n_dst, n_done, n_clr, hs_last, last_exp, rise, dcnt, scnt;
   logic ready_after, ed_prev;
   logic [2:0] pipe;
   bit gap, div_en;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      check(tag, {busy_o, done_o, data_ready_o, exp_done_o, buf_rd_en_o, div_start_o,
                  error_o, adder_rst_n_o, buf_rd_addr_o}, 12'h010);
   endtask

   task automatic clear_models();
      pipe = '0; dcnt = 0; scnt = 0;
      exp_valid_i = 1'b0; div_done_i = 1'b0; sum_valid_i = 1'b0; data_valid_i = 1'b1;
   endtask

   task automatic clear_mon();
      n_hs = 0; n_exp = 0; n_rd = 0; rd_bad = 0; n_dst = 0; n_done = 0; n_clr = 0;
      hs_last = -10; last_exp = -100; rise = -1; ready_after = 1'b1; ed_prev = 1'b0;
   endtask

   // observe the cycle that is ending, clock, then drive the stand-in models
   task automatic step();
      logic hs, st;
      if (cyc == hs_last + 1) ready_after = data_ready_o;
      if (data_valid_i && data_ready_o) begin
         n_hs++;
         if (n_hs == n) hs_last = cyc;
      end
      if (exp_valid_i) begin
         n_exp++;
         last_exp = cyc;
      end
      if (exp_done_o && !ed_prev) rise = cyc;
      ed_prev = exp_done_o;
      if (buf_rd_en_o) begin
         if (buf_rd_addr_o != 4'(n_rd)) rd_bad++;
         n_rd++;
      end
      if (div_start_o) n_dst++;
      if (done_o) n_done++;
      if (!adder_rst_n_o) n_clr++;
      hs = data_valid_i && data_ready_o;
      st = div_start_o;
      @(posedge clock_i);
      #1;
      cyc++;
      pipe = {pipe[1:0], hs};
      exp_valid_i = pipe[2];
      dcnt = st ? 4 : (dcnt > 0 ? dcnt - 1 : 0);
      div_done_i = div_en && dcnt == 1;
      scnt = exp_done_o ? scnt + 1 : 0;
      sum_valid_i = scnt == 2;
      data_valid_i = gap ? !data_valid_i : 1'b1;
   endtask

   task automatic run_pass(input string tag, input bit gap_i, input bit inj);
      clear_mon();
      gap = gap_i;
      div_en = 1'b1;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check({tag, "_clear"}, {error_o, adder_rst_n_o, data_ready_o, busy_o}, 4'b0001);
      step();
      check({tag, "_ready"}, data_ready_o, 1);
      for (int i = 0; i < 400 && n_done == 0; i++) begin
         start_i = inj && (i == 3 || (n_dst == 3 && dcnt == 3));
         step();
      end
      start_i = 1'b0;
      repeat (5) step();
      check({tag, "_hs"}, n_hs, n);
      check({tag, "_exp"}, n_exp, n);
      check({tag, "_exp_done_lag"}, rise - last_exp, 1);
      check({tag, "_ready_drop"}, ready_after, 0);
      check({tag, "_rd_cnt"}, n_rd, n);
      check({tag, "_rd_order"}, rd_bad, 0);
      check({tag, "_div_start"}, n_dst, n);
      check({tag, "_done"}, n_done, 1);
      check({tag, "_clear_cycles"}, n_clr, 1);
      check({tag, "_idle"}, {busy_o, error_o, exp_done_o, data_ready_o}, 0);
   endtask

   initial begin
      clear_models();
      clear_mon();
      repeat (2) @(posedge clock_i);
      #1;
      chk_reset("reset");
      reset_i = 1'b0;
      @(posedge clock_i);
      #1;
      run_pass("nominal", 1'b0, 1'b0);
      run_pass("gaps", 1'b1, 1'b0);
      run_pass("inject", 1'b0, 1'b1);

      clear_mon();
      gap = 1'b0;
      div_en = 1'b1;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int i = 0; i < 400 && n_dst < 6; i++) step();
      check("mid_idx", buf_rd_addr_o, 5);
      check("mid_busy", busy_o, 1);
      #2 reset_i = 1'b1;
      #1 chk_reset("rst_async");
      @(posedge clock_i);
      #1;
      chk_reset("rst_hold");
      reset_i = 1'b0;
      clear_models();
      run_pass("post_rst", 1'b0, 1'b0);

      clear_mon();
      div_en = 1'b0;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int i = 0; i < 400 && n_dst == 0; i++) step();
      check("stall_start", n_dst, 1);
      repeat (62) step();
      check("stall_64th", {done_o, error_o, busy_o}, 3'b001);
`ifdef SOFTMAX_CTRL_TIMEOUT_EN
      step();
      check("tmo_fire", {done_o, error_o, busy_o}, 3'b111);
      step();
      check("tmo_sticky", {done_o, error_o, busy_o}, 3'b010);
      clear_models();
      run_pass("after_tmo", 1'b0, 1'b0);
`else
      repeat (10) step();
      check("stall_hold", {done_o, error_o, busy_o}, 3'b001);
      check("stall_done", n_done, 0);
      reset_i = 1'b1;
      #1 chk_reset("stall_rst");
      @(posedge clock_i);
      #1;
      reset_i = 1'b0;
`endif
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
